// File: rtl/riscv_lsu_ctrl.sv
// ----------------------------------------------------------------------------
// riscv_lsu_ctrl
//
// Load/store sequencer between the RISC-V decode/execute stage and the data
// memory. It accepts one access from the core, runs a req/ready handshake with
// memory, builds byte enables, replicates store data across the word and
// sign/zero-extends load data. The core is stalled until the access retires.
//
// Parameters:
//   TIMEOUT_CYCLES  cycles spent in REQ without mem_ready_i before the access
//                   is aborted with a fault (1..1023)
//
// Ports:
//   clk_i             core clock
//   rst_i             synchronous reset, active-high
//   core_req_i        access request from decode (held stable while stalled)
//   core_we_i         1 = store, 0 = load
//   core_size_i       B=0 H=1 W=2 BU=4 HU=5 (3, 6, 7 are illegal)
//   core_addr_i       byte address
//   core_wd_i         store data
//   core_rd_o         extended load data, valid in the DONE cycle
//   core_stall_req_o  1 = hold PC/pipeline
//   core_misalign_o   rejected access (misaligned or illegal size), combinational
//   core_fault_o      memory timeout, pulses in the DONE cycle
//   mem_req_o         memory request (registered)
//   mem_we_o          memory write enable (registered)
//   mem_be_o          byte enables (registered)
//   mem_addr_o        word-aligned address (registered)
//   mem_wd_o          replicated store data (registered)
//   mem_rd_i          memory read word
//   mem_ready_i       access complete, only looked at while mem_req_o=1
// ----------------------------------------------------------------------------
module riscv_lsu_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_req_o,
    output logic        core_misalign_o,
    output logic        core_fault_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
);

    localparam int unsigned CntW = 10;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] SizeB  = 3'd0;
    localparam logic [2:0] SizeH  = 3'd1;
    localparam logic [2:0] SizeW  = 3'd2;
    localparam logic [2:0] SizeBu = 3'd4;
    localparam logic [2:0] SizeHu = 3'd5;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic            mem_req_q, mem_req_d;
    logic            mem_we_q, mem_we_d;
    logic [3:0]      mem_be_q, mem_be_d;
    logic [31:0]     mem_addr_q, mem_addr_d;
    logic [31:0]     mem_wd_q, mem_wd_d;
    logic [1:0]      off_q, off_d;
    logic [2:0]      size_q, size_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            fault_q, fault_d;
    logic [31:0]     rd_q, rd_d;

    // Request decode: legality, alignment, byte enables and store replication
    logic        size_legal;
    logic        aligned;
    logic        req_ok;
    logic [1:0]  req_off;
    logic [3:0]  req_be;
    logic [31:0] req_wd;

    assign req_off = core_addr_i[1:0];

    always_comb begin
        size_legal = 1'b0;
        aligned    = 1'b0;
        req_be     = 4'b0000;
        req_wd     = core_wd_i;
        unique case (core_size_i)
            SizeB, SizeBu: begin
                size_legal = 1'b1;
                aligned    = 1'b1;
                req_be     = 4'b0001 << req_off;
                req_wd     = {4{core_wd_i[7:0]}};
            end
            SizeH, SizeHu: begin
                size_legal = 1'b1;
                aligned    = ~req_off[0];
                req_be     = req_off[1] ? 4'b1100 : 4'b0011;
                req_wd     = {2{core_wd_i[15:0]}};
            end
            SizeW: begin
                size_legal = 1'b1;
                aligned    = (req_off == 2'b00);
                req_be     = 4'b1111;
            end
            default: begin
                size_legal = 1'b0;
                aligned    = 1'b0;
            end
        endcase
    end

    assign req_ok = size_legal & aligned;

    // Load extraction from the raw memory word using the captured offset/size
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] rd_ext;

    always_comb begin
        unique case (off_q)
            2'd0:    rd_byte = mem_rd_i[7:0];
            2'd1:    rd_byte = mem_rd_i[15:8];
            2'd2:    rd_byte = mem_rd_i[23:16];
            default: rd_byte = mem_rd_i[31:24];
        endcase
        rd_half = off_q[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];
        unique case (size_q)
            SizeB:   rd_ext = {{24{rd_byte[7]}}, rd_byte};
            SizeBu:  rd_ext = {24'd0, rd_byte};
            SizeH:   rd_ext = {{16{rd_half[15]}}, rd_half};
            SizeHu:  rd_ext = {16'd0, rd_half};
            default: rd_ext = mem_rd_i;
        endcase
    end

    // Next-state and outputs
    always_comb begin
        state_d          = state_q;
        mem_req_d        = mem_req_q;
        mem_we_d         = mem_we_q;
        mem_be_d         = mem_be_q;
        mem_addr_d       = mem_addr_q;
        mem_wd_d         = mem_wd_q;
        off_d            = off_q;
        size_d           = size_q;
        cnt_d            = cnt_q;
        fault_d          = fault_q;
        rd_d             = rd_q;
        core_stall_req_o = 1'b0;
        core_misalign_o  = 1'b0;
        core_fault_o     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (core_req_i) begin
                    if (req_ok) begin
                        core_stall_req_o = 1'b1;
                        mem_req_d        = 1'b1;
                        mem_we_d         = core_we_i;
                        mem_be_d         = req_be;
                        mem_addr_d       = {core_addr_i[31:2], 2'b00};
                        mem_wd_d         = req_wd;
                        off_d            = req_off;
                        size_d           = core_size_i;
                        cnt_d            = '0;
                        fault_d          = 1'b0;
                        state_d          = StReq;
                    end else begin
                        // Rejected without touching memory; the core is not stalled
                        core_misalign_o = 1'b1;
                    end
                end
            end

            StReq: begin
                core_stall_req_o = 1'b1;
                if (mem_ready_i) begin
                    rd_d      = rd_ext;
                    mem_req_d = 1'b0;
                    state_d   = StDone;
                end else if (cnt_q == CntLast) begin
                    rd_d      = '0;
                    mem_req_d = 1'b0;
                    fault_d   = 1'b1;
                    state_d   = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            StDone: begin
                // core_req_i here still belongs to the retiring instruction
                core_fault_o = fault_q;
                state_d      = StIdle;
            end

            default: begin
                state_d   = StIdle;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_be_q   <= 4'b0000;
            mem_addr_q <= '0;
            mem_wd_q   <= '0;
            off_q      <= 2'b00;
            size_q     <= 3'd0;
            cnt_q      <= '0;
            fault_q    <= 1'b0;
            rd_q       <= '0;
        end else begin
            state_q    <= state_d;
            mem_req_q  <= mem_req_d;
            mem_we_q   <= mem_we_d;
            mem_be_q   <= mem_be_d;
            mem_addr_q <= mem_addr_d;
            mem_wd_q   <= mem_wd_d;
            off_q      <= off_d;
            size_q     <= size_d;
            cnt_q      <= cnt_d;
            fault_q    <= fault_d;
            rd_q       <= rd_d;
        end
    end

    assign core_rd_o  = rd_q;
    assign mem_req_o  = mem_req_q;
    assign mem_we_o   = mem_we_q;
    assign mem_be_o   = mem_be_q;
    assign mem_addr_o = mem_addr_q;
    assign mem_wd_o   = mem_wd_q;

endmodule

// File: tb/tb_riscv_lsu_ctrl.sv
module tb_riscv_lsu_ctrl;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        core_req = 1'b0;
    logic        core_we = 1'b0;
    logic [2:0]  core_size = 3'd0;
    logic [31:0] core_addr = '0;
    logic [31:0] core_wd = '0;
    logic [31:0] core_rd_o;
    logic        core_stall_req_o;
    logic        core_misalign_o;
    logic        core_fault_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd = '0;
    logic        mem_ready = 1'b0;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        fault;
        int          stall_n;
        int          req_n;
    } exp_t;

    exp_t sb_q[$];

    riscv_lsu_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .core_req_i       (core_req),
        .core_we_i        (core_we),
        .core_size_i      (core_size),
        .core_addr_i      (core_addr),
        .core_wd_i        (core_wd),
        .core_rd_o        (core_rd_o),
        .core_stall_req_o (core_stall_req_o),
        .core_misalign_o  (core_misalign_o),
        .core_fault_o     (core_fault_o),
        .mem_req_o        (mem_req_o),
        .mem_we_o         (mem_we_o),
        .mem_be_o         (mem_be_o),
        .mem_addr_o       (mem_addr_o),
        .mem_wd_o         (mem_wd_o),
        .mem_rd_i         (mem_rd),
        .mem_ready_i      (mem_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] m_be(input logic [2:0] sz, input logic [1:0] off);
        case (sz)
            3'd0, 3'd4: begin
                case (off)
                    2'd0:    return 4'b0001;
                    2'd1:    return 4'b0010;
                    2'd2:    return 4'b0100;
                    default: return 4'b1000;
                endcase
            end
            3'd1, 3'd5: return (off >= 2'd2) ? 4'b1100 : 4'b0011;
            default:    return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] m_wd(input logic [2:0] sz, input logic [31:0] wd);
        case (sz)
            3'd0, 3'd4: return {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
            3'd1, 3'd5: return {wd[15:0], wd[15:0]};
            default:    return wd;
        endcase
    endfunction

    function automatic logic [31:0] m_rd(input logic [2:0] sz, input logic [1:0] off,
                                         input logic [31:0] m);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = m[7:0];
            2'd1:    b = m[15:8];
            2'd2:    b = m[23:16];
            default: b = m[31:24];
        endcase
        h = (off >= 2'd2) ? m[31:16] : m[15:0];
        case (sz)
            3'd0:    return {{24{b[7]}}, b};
            3'd4:    return {24'd0, b};
            3'd1:    return {{16{h[15]}}, h};
            3'd5:    return {16'd0, h};
            default: return m;
        endcase
    endfunction

    // Drive one access, answer it from a tiny memory model and check it at DONE.
    // ready_at < 0 means memory never answers. Returns at DONE (negedge + 1).
    task automatic run_access(input logic we, input logic [2:0] sz, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [31:0] mword,
                              input int ready_at, input logic drop_req);
        exp_t e;
        exp_t got;
        int   stall_n;
        int   req_n;
        int   cyc;
        logic done;
        e.we      = we;
        e.be      = m_be(sz, addr[1:0]);
        e.addr    = {addr[31:2], 2'b00};
        e.wd      = m_wd(sz, wd);
        e.fault   = (ready_at < 0);
        e.rd      = e.fault ? 32'd0 : m_rd(sz, addr[1:0], mword);
        e.stall_n = e.fault ? int'(TO) + 1 : ready_at + 2;
        e.req_n   = e.fault ? int'(TO) : ready_at + 1;
        sb_q.push_back(e);

        @(negedge clk);
        core_req  = 1'b1;
        core_we   = we;
        core_size = sz;
        core_addr = addr;
        core_wd   = wd;
        mem_rd    = mword;
        mem_ready = 1'b0;
        stall_n = 0;
        req_n   = 0;
        cyc     = 0;
        done    = 1'b0;
        while (!done && cyc < 2000) begin
            #1;
            if (core_stall_req_o) begin
                stall_n++;
                if (mem_req_o) begin
                    if (req_n == 0) begin
                        total++;
                        if ({mem_we_o, mem_be_o, mem_addr_o, mem_wd_o} !==
                            {e.we, e.be, e.addr, e.wd}) begin
                            bad++;
                            $display("FAIL bus: got we=%b be=%b addr=%h wd=%h want we=%b be=%b addr=%h wd=%h",
                                     mem_we_o, mem_be_o, mem_addr_o, mem_wd_o,
                                     e.we, e.be, e.addr, e.wd);
                        end
                    end
                    mem_ready = (req_n == ready_at);
                    req_n++;
                end else begin
                    mem_ready = 1'b0;
                end
                cyc++;
                @(negedge clk);
            end else begin
                done = 1'b1;
            end
        end
        mem_ready = 1'b0;
        if (!done) begin
            total++;
            bad++;
            $display("FAIL timeout: access addr=%h never completed", addr);
            void'(sb_q.pop_front());
        end else begin
            got = sb_q.pop_front();
            total++;
            if (core_rd_o !== got.rd || core_fault_o !== got.fault) begin
                bad++;
                $display("FAIL done_data: got rd=%h fault=%b want rd=%h fault=%b",
                         core_rd_o, core_fault_o, got.rd, got.fault);
            end
            total++;
            if (stall_n != got.stall_n || req_n != got.req_n || mem_req_o !== 1'b0) begin
                bad++;
                $display("FAIL timing: got stall=%0d req=%0d mem_req=%b want stall=%0d req=%0d mem_req=0",
                         stall_n, req_n, mem_req_o, got.stall_n, got.req_n);
            end
        end
        if (drop_req) core_req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        core_req = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if ({mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o} !== 70'd0) begin
            bad++;
            $display("FAIL reset_bus: got req=%b we=%b be=%b addr=%h wd=%h want all 0",
                     mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o);
        end
        total++;
        if (core_rd_o !== 32'd0) begin
            bad++;
            $display("FAIL reset_rd: got %h want 00000000", core_rd_o);
        end
        total++;
        if ({core_stall_req_o, core_misalign_o, core_fault_o} !== 3'b000) begin
            bad++;
            $display("FAIL reset_flags: got %b want 000",
                     {core_stall_req_o, core_misalign_o, core_fault_o});
        end
        rst = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        core_req = 1'b1; core_we = 1'b0; core_size = 3'd2; core_addr = 32'h40;
        mem_rd = 32'h1111_2222; mem_ready = 1'b0;
        @(negedge clk);
        #1;
        total++;
        if (mem_req_o !== 1'b1) begin
            bad++;
            $display("FAIL mid_req: got mem_req=%b want 1", mem_req_o);
        end
        rst = 1'b1; core_req = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if ({mem_req_o, core_stall_req_o} !== 2'b00) begin
            bad++;
            $display("FAIL mid_reset: got req=%b stall=%b want 0 0", mem_req_o, core_stall_req_o);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        total++;
        if ({mem_req_o, core_stall_req_o, core_fault_o} !== 3'b000 || core_rd_o !== 32'd0) begin
            bad++;
            $display("FAIL mid_after: got req=%b stall=%b fault=%b rd=%h want 0 0 0 00000000",
                     mem_req_o, core_stall_req_o, core_fault_o, core_rd_o);
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_load_word();
        run_access(1'b0, 3'd2, 32'h104, 32'd0, 32'hDEAD_BEEF, 0, 1'b1);
    endtask

    task automatic test_load_byte();
        run_access(1'b0, 3'd0, 32'h203, 32'd0, 32'h80FF_FF7F, 0, 1'b1);
        run_access(1'b0, 3'd4, 32'h203, 32'd0, 32'h80FF_FF7F, 0, 1'b1);
        run_access(1'b0, 3'd1, 32'h202, 32'd0, 32'h80FF_FF7F, 2, 1'b1);
        run_access(1'b0, 3'd5, 32'h200, 32'd0, 32'h80FF_8F7F, 1, 1'b1);
    endtask

    task automatic test_store_half();
        run_access(1'b1, 3'd1, 32'h12, 32'h1234_ABCD, 32'd0, 0, 1'b1);
        run_access(1'b1, 3'd0, 32'h21, 32'h0000_005A, 32'd0, 1, 1'b1);
    endtask

    task automatic test_misalign();
        logic [2:0]  szs [4];
        logic [31:0] adrs[4];
        szs[0] = 3'd2; adrs[0] = 32'h101;
        szs[1] = 3'd1; adrs[1] = 32'h103;
        szs[2] = 3'd3; adrs[2] = 32'h100;
        szs[3] = 3'd7; adrs[3] = 32'h200;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            core_req = 1'b1; core_we = 1'b0; core_size = szs[i]; core_addr = adrs[i];
            #1;
            total++;
            if ({core_misalign_o, core_stall_req_o} !== 2'b10) begin
                bad++;
                $display("FAIL misalign[%0d]: got mis=%b stall=%b want 1 0",
                         i, core_misalign_o, core_stall_req_o);
            end
            core_req = 1'b0;
            repeat (2) @(negedge clk);
            #1;
            total++;
            if ({mem_req_o, core_misalign_o} !== 2'b00) begin
                bad++;
                $display("FAIL misalign_noreq[%0d]: got req=%b mis=%b want 0 0",
                         i, mem_req_o, core_misalign_o);
            end
        end
    endtask

    task automatic test_timeout();
        run_access(1'b0, 3'd2, 32'h400, 32'd0, 32'hCAFE_F00D, -1, 1'b1);
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            total++;
            if ({mem_req_o, core_stall_req_o, core_fault_o} !== 3'b000 || core_rd_o !== 32'd0) begin
                bad++;
                $display("FAIL late_ready[%0d]: got req=%b stall=%b fault=%b rd=%h want 0 0 0 00000000",
                         i, mem_req_o, core_stall_req_o, core_fault_o, core_rd_o);
            end
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        // Request stays high through DONE; it must not start a second access
        run_access(1'b0, 3'd2, 32'h300, 32'd0, 32'h0BAD_F00D, 0, 1'b0);
        @(negedge clk);
        #1;
        total++;
        if ({mem_req_o, core_stall_req_o} !== 2'b01) begin
            bad++;
            $display("FAIL done_ignore: got req=%b stall=%b want 0 1", mem_req_o, core_stall_req_o);
        end
        core_req = 1'b0;
        run_access(1'b1, 3'd2, 32'h304, 32'h7654_3210, 32'h0, 0, 1'b1);
    endtask

    task automatic test_random();
        logic [2:0]  tab[5];
        logic [2:0]  sz;
        logic [31:0] a;
        tab[0] = 3'd0; tab[1] = 3'd1; tab[2] = 3'd2; tab[3] = 3'd4; tab[4] = 3'd5;
        for (int i = 0; i < 10; i++) begin
            sz = tab[$urandom_range(0, 4)];
            a  = $urandom;
            if (sz == 3'd2) a[1:0] = 2'b00;
            else if (sz == 3'd1 || sz == 3'd5) a[0] = 1'b0;
            run_access(1'($urandom_range(0, 1)), sz, a, $urandom, $urandom,
                       int'($urandom_range(0, 2)), 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_load_word();
        test_load_byte();
        test_store_half();
        test_misalign();
        test_timeout();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
